// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer slice.
//   entry_state_e : lifecycle of one ROB entry (empty -> issued -> done -> empty)
//   rob_size()    : entry count derived from log2 size
//   wb_slice_lo() : bit offset of one channel's field inside a packed writeback bus
package rob_pkg;

  typedef enum logic [1:0] {
    EntryEmpty  = 2'd0,
    EntryIssued = 2'd1,
    EntryDone   = 2'd2
  } entry_state_e;

  localparam int unsigned NumArchRegs = 32;
  localparam int unsigned RegIdW      = 5;

  function automatic int unsigned rob_size(input int unsigned size_bits);
    return 32'd1 << size_bits;
  endfunction

  function automatic int unsigned wb_slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rob_rename_table.sv
// Register rename table: per architectural register, a busy bit and the tag of the
// youngest in-flight producer.
//   clk_in, rst_in         : clock, asynchronous active-high reset
//   en                     : global advance enable (state frozen when low)
//   clear                  : return every register to not-busy
//   issue_en/rd/tag        : new producer for issue_rd
//   commit_en/rd/tag       : retiring producer; clears only if still the youngest
//   rs1_id/rs2_id          : lookup ports -> busy flag and producer tag
module rob_rename_table
  import rob_pkg::*;
#(
  parameter int unsigned TAG_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en,
  input  logic              clear,
  input  logic              issue_en,
  input  logic [RegIdW-1:0] issue_rd,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic              commit_en,
  input  logic [RegIdW-1:0] commit_rd,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic [RegIdW-1:0] rs1_id,
  input  logic [RegIdW-1:0] rs2_id,
  output logic              rs1_busy,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic              rs2_busy,
  output logic [TAG_W-1:0]  rs2_tag
);

  logic [NumArchRegs-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]       tag_q [NumArchRegs];
  logic [TAG_W-1:0]       tag_d [NumArchRegs];

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (clear) begin
      busy_d = '0;
      for (int i = 0; i < int'(NumArchRegs); i++) tag_d[i] = '0;
    end else begin
      // A younger producer renamed rd in the meantime: leave it busy.
      if (commit_en && tag_q[commit_rd] == commit_tag) busy_d[commit_rd] = 1'b0;
      // Issue after commit so a same-cycle rename of the same rd wins.
      if (issue_en && issue_rd != '0) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_tag;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < int'(NumArchRegs); i++) tag_q[i] <= '0;
    end else if (en) begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign rs1_busy = busy_q[rs1_id];
  assign rs1_tag  = tag_q[rs1_id];
  assign rs2_busy = busy_q[rs2_id];
  assign rs2_tag  = tag_q[rs2_id];

endmodule

// File: rtl/reorder_buffer_mc.sv
// Multi-writeback-channel reorder buffer with integrated rename table.
//   clk_in, rst_in          : clock, asynchronous active-high reset
//   rdy_in                  : global stall, all state frozen when low
//   issue_*                 : in-order allocation; issue_tag is the granted entry (tail)
//   q_rs*_id / q_rs*_*      : operand lookup (ready, producer tag, value)
//   rf_rs*_val              : register-file read data for the lookup ids
//   wb_valid/tag/res/PC     : NUM_WB packed out-of-order writeback channels
//   rf_is_writing_rd/...    : combinational in-order commit to the register file
//   flush_pipline/reset_PC_to : registered one-cycle misprediction redirect
//   rob_count               : occupancy
module reorder_buffer_mc
  import rob_pkg::*;
#(
  parameter int unsigned ROB_SIZE_BITS = 3,
  parameter int unsigned NUM_WB        = 2,
  parameter int unsigned XLEN          = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  output logic [ROB_SIZE_BITS-1:0]   issue_tag,
  input  logic [4:0]                 issue_rd,
  input  logic [XLEN-1:0]            issue_predicted_PC,
  input  logic [4:0]                 q_rs1_id,
  input  logic [4:0]                 q_rs2_id,
  output logic                       q_rs1_ready,
  output logic                       q_rs2_ready,
  output logic [ROB_SIZE_BITS-1:0]   q_rs1_tag,
  output logic [ROB_SIZE_BITS-1:0]   q_rs2_tag,
  output logic [XLEN-1:0]            q_rs1_val,
  output logic [XLEN-1:0]            q_rs2_val,
  input  logic [XLEN-1:0]            rf_rs1_val,
  input  logic [XLEN-1:0]            rf_rs2_val,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*ROB_SIZE_BITS-1:0] wb_tag,
  input  logic [NUM_WB*XLEN-1:0]     wb_res,
  input  logic [NUM_WB*XLEN-1:0]     wb_resulting_PC,
  output logic                       rf_is_writing_rd,
  output logic [4:0]                 rf_rd_reg_id,
  output logic [XLEN-1:0]            rf_rd_val,
  output logic                       flush_pipline,
  output logic [XLEN-1:0]            reset_PC_to,
  output logic [ROB_SIZE_BITS:0]     rob_count
);

  localparam int unsigned TagW    = ROB_SIZE_BITS;
  localparam int unsigned CntW    = ROB_SIZE_BITS + 1;
  localparam int unsigned RobSize = rob_size(ROB_SIZE_BITS);
  localparam logic [CntW-1:0] RobSizeCnt = CntW'(RobSize);

  logic [TagW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  entry_state_e     state_q [RobSize];
  entry_state_e     state_d [RobSize];
  logic [4:0]       rd_q    [RobSize];
  logic [4:0]       rd_d    [RobSize];
  logic [XLEN-1:0]  pred_q  [RobSize];
  logic [XLEN-1:0]  pred_d  [RobSize];
  logic [XLEN-1:0]  res_q   [RobSize];
  logic [XLEN-1:0]  res_d   [RobSize];
  logic [XLEN-1:0]  act_q   [RobSize];
  logic [XLEN-1:0]  act_d   [RobSize];
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  reset_pc_q, reset_pc_d;

  logic [TagW-1:0]  wb_tag_ch [NUM_WB];
  logic [XLEN-1:0]  wb_res_ch [NUM_WB];
  logic [XLEN-1:0]  wb_pc_ch  [NUM_WB];
  logic [RobSize-1:0] wb_claimed;

  logic             do_issue, do_commit;
  logic             rs1_busy, rs2_busy;
  logic [TagW-1:0]  rs1_tag, rs2_tag;

  always_comb begin
    for (int c = 0; c < int'(NUM_WB); c++) begin
      wb_tag_ch[c] = wb_tag[wb_slice_lo(c, TagW) +: TagW];
      wb_res_ch[c] = wb_res[wb_slice_lo(c, XLEN) +: XLEN];
      wb_pc_ch[c]  = wb_resulting_PC[wb_slice_lo(c, XLEN) +: XLEN];
    end
  end

  assign issue_ready = (count_q < RobSizeCnt) && !flush_q;
  assign do_issue    = issue_valid && issue_ready && rdy_in;
  assign do_commit   = (count_q != '0) && (state_q[head_q] == EntryDone) && rdy_in && !flush_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    rd_d       = rd_q;
    pred_d     = pred_q;
    res_d      = res_q;
    act_d      = act_q;
    flush_d    = 1'b0;
    reset_pc_d = '0;
    wb_claimed = '0;
    if (flush_q) begin
      // Flush cycle: drop everything in flight, ignore this cycle's traffic.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int i = 0; i < int'(RobSize); i++) state_d[i] = EntryEmpty;
    end else begin
      // Ascending scan with a claim mask so the lowest channel wins a shared tag.
      for (int c = 0; c < int'(NUM_WB); c++) begin
        if (wb_valid[c] && state_q[wb_tag_ch[c]] == EntryIssued && !wb_claimed[wb_tag_ch[c]]) begin
          wb_claimed[wb_tag_ch[c]] = 1'b1;
          state_d[wb_tag_ch[c]]    = EntryDone;
          res_d[wb_tag_ch[c]]      = wb_res_ch[c];
          act_d[wb_tag_ch[c]]      = wb_pc_ch[c];
        end
      end
      if (do_issue) begin
        state_d[tail_q] = EntryIssued;
        rd_d[tail_q]    = issue_rd;
        pred_d[tail_q]  = issue_predicted_PC;
        tail_d          = tail_q + 1'b1;
      end
      if (do_commit) begin
        state_d[head_q] = EntryEmpty;
        head_d          = head_q + 1'b1;
        if (act_q[head_q] != pred_q[head_q]) begin
          flush_d    = 1'b1;
          reset_pc_d = act_q[head_q];
        end
      end
      unique case ({do_issue, do_commit})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      reset_pc_q <= '0;
      for (int i = 0; i < int'(RobSize); i++) begin
        state_q[i] <= EntryEmpty;
        rd_q[i]    <= '0;
        pred_q[i]  <= '0;
        res_q[i]   <= '0;
        act_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      // Holding on !rdy_in also keeps a pending flush until the stall lifts.
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      reset_pc_q <= reset_pc_d;
      state_q    <= state_d;
      rd_q       <= rd_d;
      pred_q     <= pred_d;
      res_q      <= res_d;
      act_q      <= act_d;
    end
  end

  rob_rename_table #(
    .TAG_W (TagW)
  ) u_rename (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en         (rdy_in),
    .clear      (flush_q),
    .issue_en   (do_issue),
    .issue_rd   (issue_rd),
    .issue_tag  (tail_q),
    .commit_en  (do_commit),
    .commit_rd  (rd_q[head_q]),
    .commit_tag (head_q),
    .rs1_id     (q_rs1_id),
    .rs2_id     (q_rs2_id),
    .rs1_busy   (rs1_busy),
    .rs1_tag    (rs1_tag),
    .rs2_busy   (rs2_busy),
    .rs2_tag    (rs2_tag)
  );

  // Lookups see registered state only; a same-cycle writeback is not forwarded.
  assign q_rs1_ready = !rs1_busy || (state_q[rs1_tag] == EntryDone);
  assign q_rs2_ready = !rs2_busy || (state_q[rs2_tag] == EntryDone);
  assign q_rs1_tag   = rs1_tag;
  assign q_rs2_tag   = rs2_tag;
  assign q_rs1_val   = rs1_busy ? res_q[rs1_tag] : rf_rs1_val;
  assign q_rs2_val   = rs2_busy ? res_q[rs2_tag] : rf_rs2_val;

  assign issue_tag        = tail_q;
  assign rf_is_writing_rd = do_commit;
  assign rf_rd_reg_id     = rd_q[head_q];
  assign rf_rd_val        = res_q[head_q];
  assign flush_pipline    = flush_q;
  assign reset_PC_to      = reset_pc_q;
  assign rob_count        = count_q;

endmodule
